// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM encoding, config-word
// field offsets and default geometry.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int FWD_INV_BIT = 0;
    localparam int SCH_LSB     = 1;

    localparam int DEF_N_LOG2 = 10;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/fft_frame_counter.sv
// Per-frame sample index with tlast generation and a frame counter that
// flags the final frame of a bounded run; target 0 means unbounded.
module fft_frame_counter #(
    parameter int N_LOG2 = 10,
    parameter int FRM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat,
    input  logic [FRM_W-1:0]  target,
    output logic [N_LOG2-1:0] idx,
    output logic              tlast,
    output logic [FRM_W-1:0]  frames,
    output logic              last_frame
);

    localparam logic [N_LOG2-1:0] IDX_MAX = '1;
    localparam logic [FRM_W-1:0]  FRM_MAX = '1;

    logic             continuous;
    logic [FRM_W:0]   frames_inc;

    assign continuous = (target == '0);
    assign frames_inc = {1'b0, frames} + (FRM_W + 1)'(1);
    assign tlast      = (idx == IDX_MAX);
    // Compared one bit wider so a saturated count never aliases onto target.
    assign last_frame = !continuous && (frames_inc == {1'b0, target});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx    <= '0;
            frames <= '0;
        end else if (beat) begin
            idx <= idx + N_LOG2'(1);
            if (tlast) begin
                if (continuous || (frames != FRM_MAX)) begin
                    frames <= frames_inc[FRM_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Drives the streaming FFT core: one config word per run, then exactly N
// samples per frame with generated tlast, until the frame target or an abort.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N_LOG2 = DEF_N_LOG2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SCH_W  = 10,
    parameter int CFG_W  = 16,
    parameter int FRM_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_fwd_inv,
    input  logic [SCH_W-1:0]  i_scale_sch,
    input  logic [FRM_W-1:0]  i_frames,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [CFG_W-1:0]  o_cfg_tdata,
    output logic              o_cfg_tvalid,
    input  logic              i_cfg_tready,
    output logic [DATA_W-1:0] o_fft_tdata,
    output logic              o_fft_tvalid,
    output logic              o_fft_tlast,
    input  logic              i_fft_tready,
    input  logic              i_out_valid,
    input  logic              i_out_ready,
    input  logic              i_out_last,
    input  logic              i_evt_tlast_unexp,
    input  logic              i_evt_tlast_miss,
    output logic              o_busy,
    output logic              o_done,
    output logic [FRM_W-1:0]  o_in_frames,
    output logic [FRM_W-1:0]  o_out_frames,
    output logic              o_err,
    output state_t            o_state
);

    localparam logic [FRM_W-1:0] FRM_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic [CFG_W-1:0]    cfg_word;
    logic [FRM_W-1:0]    frames_q;
    logic                abort_pending;
    logic                start_run;
    logic                in_stream;
    logic                beat;
    logic                out_frame_done;
    logic [N_LOG2-1:0]   idx;
    logic                tlast;
    logic                last_frame;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; a source holds valid and data stable until that cycle.
    assign start_run      = (state == ST_IDLE) && i_start;
    assign in_stream      = (state == ST_STREAM);
    assign beat           = in_stream && i_data_valid && i_fft_tready;
    assign out_frame_done = (state != ST_IDLE) && i_out_valid && i_out_ready && i_out_last;

    assign o_fft_tdata  = i_data;
    assign o_fft_tvalid = in_stream && i_data_valid;
    assign o_data_ready = in_stream && i_fft_tready;
    assign o_fft_tlast  = in_stream && tlast;
    assign o_cfg_tvalid = (state == ST_CFG);
    assign o_busy       = (state != ST_IDLE);
    assign o_state      = state;

    always_comb begin
        cfg_word                     = '0;
        cfg_word[FWD_INV_BIT]        = i_fwd_inv;
        cfg_word[SCH_LSB +: SCH_W]   = i_scale_sch;
    end

    fft_frame_counter #(
        .N_LOG2 (N_LOG2),
        .FRM_W  (FRM_W)
    ) u_in_counter (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (start_run),
        .beat       (beat),
        .target     (frames_q),
        .idx        (idx),
        .tlast      (tlast),
        .frames     (o_in_frames),
        .last_frame (last_frame)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_CFG;
            end
            ST_CFG: begin
                if (i_abort) begin
                    state_nxt = ST_DRAIN;
                end else if (i_cfg_tready) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A frame already in flight always completes before draining.
                if (beat && tlast && (last_frame || abort_pending || i_abort)) begin
                    state_nxt = ST_DRAIN;
                end else if (i_abort && (idx == '0) && !beat) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (o_out_frames == o_in_frames) begin
                    o_done    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cfg_tdata   <= '0;
            frames_q      <= '0;
            abort_pending <= 1'b0;
            o_err         <= 1'b0;
            o_out_frames  <= '0;
        end else if (start_run) begin
            o_cfg_tdata   <= cfg_word;
            frames_q      <= i_frames;
            abort_pending <= 1'b0;
            o_err         <= 1'b0;
            o_out_frames  <= '0;
        end else begin
            if (in_stream && i_abort) abort_pending <= 1'b1;
            if ((state != ST_IDLE) && (i_evt_tlast_unexp || i_evt_tlast_miss)) o_err <= 1'b1;
            if (out_frame_done && (o_out_frames != FRM_MAX)) begin
                o_out_frames <= o_out_frames + FRM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N = 8 points per frame.
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    localparam int N_LOG2 = 3;
    localparam int N      = 8;
    localparam int DATA_W = 32;
    localparam int SCH_W  = 10;
    localparam int CFG_W  = 16;
    localparam int FRM_W  = 16;

    logic              clk;
    logic              i_rst, i_start, i_abort, i_fwd_inv;
    logic [SCH_W-1:0]  i_scale_sch;
    logic [FRM_W-1:0]  i_frames;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid, o_data_ready;
    logic [CFG_W-1:0]  o_cfg_tdata;
    logic              o_cfg_tvalid, i_cfg_tready;
    logic [DATA_W-1:0] o_fft_tdata;
    logic              o_fft_tvalid, o_fft_tlast, i_fft_tready;
    logic              i_out_valid, i_out_ready, i_out_last;
    logic              i_evt_tlast_unexp, i_evt_tlast_miss;
    logic              o_busy, o_done, o_err;
    logic [FRM_W-1:0]  o_in_frames, o_out_frames;
    state_t            o_state;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic             fwd;
        logic [SCH_W-1:0] sch;
        logic [CFG_W-1:0] exp_cfg;
    } cfg_vec_t;
    cfg_vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .N_LOG2(N_LOG2), .DATA_W(DATA_W), .SCH_W(SCH_W), .CFG_W(CFG_W), .FRM_W(FRM_W)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_fwd_inv(i_fwd_inv), .i_scale_sch(i_scale_sch), .i_frames(i_frames),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .o_cfg_tdata(o_cfg_tdata), .o_cfg_tvalid(o_cfg_tvalid), .i_cfg_tready(i_cfg_tready),
        .o_fft_tdata(o_fft_tdata), .o_fft_tvalid(o_fft_tvalid), .o_fft_tlast(o_fft_tlast),
        .i_fft_tready(i_fft_tready), .i_out_valid(i_out_valid), .i_out_ready(i_out_ready),
        .i_out_last(i_out_last), .i_evt_tlast_unexp(i_evt_tlast_unexp),
        .i_evt_tlast_miss(i_evt_tlast_miss), .o_busy(o_busy), .o_done(o_done),
        .o_in_frames(o_in_frames), .o_out_frames(o_out_frames), .o_err(o_err),
        .o_state(o_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_run(input logic fwd, input logic [SCH_W-1:0] sch, input logic [FRM_W-1:0] frames);
        i_fwd_inv   = fwd;
        i_scale_sch = sch;
        i_frames    = frames;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic accept_cfg;
        i_cfg_tready = 1'b1;
        tick();
        i_cfg_tready = 1'b0;
    endtask

    // Offers base+k in order; gap_pct gives the chance of valid/ready being low.
    task automatic stream(input int n_beats, input int gap_pct, input logic [31:0] base, input int abort_beat);
        int k;
        int cyc;
        logic v;
        logic r;
        logic [DATA_W-1:0] e;
        k   = 0;
        cyc = 0;
        for (int j = 0; j < n_beats; j++) exp_q.push_back(base + j);
        while (k < n_beats && cyc < 2000) begin
            v = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
            r = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
            i_data_valid = v;
            i_fft_tready = r;
            i_data       = base + k;
            i_abort      = (k == abort_beat) && v && r;
            #1;
            chk("tvalid_pass", o_fft_tvalid, v);
            chk("ready_pass", o_data_ready, r);
            if (v && r) begin
                e = exp_q.pop_front();
                chk("beat_data", o_fft_tdata, e);
                chk("beat_tlast", o_fft_tlast, (k % N) == N - 1);
                k++;
            end
            tick();
            cyc++;
        end
        i_data_valid = 1'b0;
        i_fft_tready = 1'b0;
        i_abort      = 1'b0;
        if (k < n_beats) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", k, n_beats);
            exp_q.delete();
        end
    endtask

    task automatic check_drain(input logic [FRM_W-1:0] exp_in);
        i_data_valid = 1'b1;
        i_fft_tready = 1'b1;
        #1;
        chk("drain_state", o_state, ST_DRAIN);
        chk("drain_tvalid", o_fft_tvalid, 1'b0);
        chk("drain_ready", o_data_ready, 1'b0);
        chk("in_frames", o_in_frames, exp_in);
        i_data_valid = 1'b0;
        i_fft_tready = 1'b0;
    endtask

    // Core output side: a non-last beat first, then n frame-closing beats.
    task automatic out_frames(input int n);
        i_out_valid = 1'b1;
        i_out_ready = 1'b1;
        i_out_last  = 1'b0;
        tick();
        i_out_valid = 1'b0;
        i_out_ready = 1'b0;
        #1;
        chk("out_nonlast", o_out_frames, 0);
        for (int i = 0; i < n; i++) begin
            i_out_valid = 1'b1;
            i_out_ready = 1'b1;
            i_out_last  = 1'b1;
            #1;
            chk("done_early", o_done, 1'b0);
            tick();
            i_out_valid = 1'b0;
            i_out_ready = 1'b0;
            i_out_last  = 1'b0;
            #1;
            chk("out_frames", o_out_frames, i + 1);
            chk("done_pulse", o_done, i == n - 1);
            tick();
        end
        chk("done_one_cycle", o_done, 1'b0);
        chk("idle_after_done", o_busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{fwd: 1'b0, sch: 10'h000, exp_cfg: 16'h0000};
        vecs[1] = '{fwd: 1'b1, sch: 10'h3FF, exp_cfg: 16'h07FF};
        vecs[2] = '{fwd: 1'b0, sch: 10'h200, exp_cfg: 16'h0400};
        vecs[3] = '{fwd: 1'b1, sch: 10'h155, exp_cfg: 16'h02AB};

        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_fwd_inv = 1'b0;
        i_scale_sch = '0; i_frames = '0; i_data = '0; i_data_valid = 1'b0;
        i_cfg_tready = 1'b0; i_fft_tready = 1'b0; i_out_valid = 1'b0;
        i_out_ready = 1'b0; i_out_last = 1'b0; i_evt_tlast_unexp = 1'b0;
        i_evt_tlast_miss = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        i_data_valid = 1'b1;
        i_fft_tready = 1'b1;
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_cfg_tvalid", o_cfg_tvalid, 1'b0);
        chk("rst_cfg_tdata", o_cfg_tdata, 16'h0000);
        chk("rst_ready", o_data_ready, 1'b0);
        chk("rst_tvalid", o_fft_tvalid, 1'b0);
        chk("rst_tlast", o_fft_tlast, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_in_frames", o_in_frames, 0);
        chk("rst_out_frames", o_out_frames, 0);
        i_data_valid = 1'b0;
        i_fft_tready = 1'b0;
        tick();

        // Two frames with config stalled for five cycles.
        start_run(1'b1, 10'h2AB, 16'd2);
        i_fft_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("cfg_tvalid_hold", o_cfg_tvalid, 1'b1);
            chk("cfg_tdata_hold", o_cfg_tdata, 16'h0557);
            chk("cfg_ready_low", o_data_ready, 1'b0);
            tick();
        end
        i_fft_tready = 1'b0;
        accept_cfg();
        chk("stream_entered", o_state, ST_STREAM);
        chk("cfg_tvalid_drop", o_cfg_tvalid, 1'b0);
        stream(16, 0, 32'h1000_0000, -1);
        check_drain(16'd2);
        out_frames(2);

        // Three frames with random gaps on both sides.
        start_run(1'b0, 10'h0F0, 16'd3);
        accept_cfg();
        stream(24, 30, 32'h2000_0000, -1);
        check_drain(16'd3);
        out_frames(3);

        // Continuous mode, abort on the fifth beat of the fourth frame.
        start_run(1'b1, 10'h001, 16'd0);
        accept_cfg();
        stream(32, 0, 32'h3000_0000, 28);
        check_drain(16'd4);
        out_frames(4);

        // Reset in the middle of a frame.
        start_run(1'b1, 10'h2AB, 16'd1);
        accept_cfg();
        stream(3, 0, 32'h4000_0000, -1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_fft_tready = 1'b1;
        i_data_valid = 1'b1;
        #1;
        chk("midrst_state", o_state, ST_IDLE);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_cfg_tdata", o_cfg_tdata, 16'h0000);
        chk("midrst_ready", o_data_ready, 1'b0);
        chk("midrst_tvalid", o_fft_tvalid, 1'b0);
        chk("midrst_in_frames", o_in_frames, 0);
        i_fft_tready = 1'b0;
        i_data_valid = 1'b0;
        tick();

        // Fresh run after reset with a core error event during streaming.
        start_run(1'b0, 10'h111, 16'd1);
        accept_cfg();
        chk("err_before_evt", o_err, 1'b0);
        i_evt_tlast_miss = 1'b1;
        tick();
        i_evt_tlast_miss = 1'b0;
        chk("err_set", o_err, 1'b1);
        stream(8, 0, 32'h5000_0000, -1);
        check_drain(16'd1);
        chk("err_in_drain", o_err, 1'b1);
        out_frames(1);
        chk("err_sticky_idle", o_err, 1'b1);

        // Abort in STREAM at a frame boundary with no beat: drains at once.
        start_run(1'b1, 10'h0AA, 16'd0);
        chk("err_cleared", o_err, 1'b0);
        accept_cfg();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_idle_done", o_done, 1'b1);
        chk("abort_idle_busy", o_busy, 1'b1);
        tick();
        chk("abort_idle_back", o_busy, 1'b0);

        // Config-word table, each run aborted while still in CFG.
        for (int v = 0; v < 4; v++) begin
            start_run(vecs[v].fwd, vecs[v].sch, 16'd1);
            chk("tbl_cfg_tvalid", o_cfg_tvalid, 1'b1);
            chk("tbl_cfg_tdata", o_cfg_tdata, vecs[v].exp_cfg);
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            chk("tbl_abort_done", o_done, 1'b1);
            chk("tbl_abort_in", o_in_frames, 0);
            tick();
            chk("tbl_idle", o_busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
